// File: rtl/rf_pkg.sv
// Shared register-file definitions used by write-back, decode and hazard logic.
package rf_pkg;
  localparam int AW   = 5;
  localparam int DW   = 32;
  localparam int NREG = 32;
  typedef logic [AW-1:0] reg_addr_t;
  localparam reg_addr_t REG_ZERO = 5'd0;
endpackage

// File: rtl/rf_scoreboard.sv
// Busy vector for registers with an outstanding B write; lookups are combinational.
// Set on issue, clear when the B write reaches the register file (set wins on the same edge).
module rf_scoreboard
  import rf_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          issue_valid,
  input  logic [AW-1:0] issue_rd,
  output logic          issue_ready,
  input  logic [AW-1:0] q_ra1,
  input  logic [AW-1:0] q_ra2,
  output logic          q_busy1,
  output logic          q_busy2,
  input  logic          clr_en,
  input  logic [AW-1:0] clr_addr
);

  logic [NREG-1:0] busy_q, busy_d;
  logic            set_en;

  assign issue_ready = !busy_q[issue_rd];
  assign set_en      = issue_valid && issue_ready && (issue_rd != REG_ZERO);
  assign q_busy1     = (q_ra1 != REG_ZERO) && busy_q[q_ra1];
  assign q_busy2     = (q_ra2 != REG_ZERO) && busy_q[q_ra2];

  always_comb begin
    busy_d = busy_q;
    if (clr_en) busy_d[clr_addr] = 1'b0;
    // Applied after the clear so a same-edge issue keeps the register busy.
    if (set_en) busy_d[issue_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_q <= '0;
    else        busy_q <= busy_d;
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Shares the register-file write port between ALU (A) and long-latency unit (B, via one hold entry).
// Grant in cycle N drives rf_* in N+1; a held B write is forced through after MAX_WAIT lost cycles.
module rf_wb_arbiter
  import rf_pkg::*;
#(
  parameter int AW       = rf_pkg::AW,
  parameter int DW       = rf_pkg::DW,
  parameter int MAX_WAIT = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          a_valid,
  output logic          a_ready,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_data,
  input  logic          b_valid,
  output logic          b_ready,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_data,
  input  logic          issue_valid,
  input  logic [AW-1:0] issue_rd,
  output logic          issue_ready,
  input  logic [AW-1:0] q_ra1,
  input  logic [AW-1:0] q_ra2,
  output logic          q_busy1,
  output logic          q_busy2,
  output logic          rf_we,
  output logic [AW-1:0] rf_wa,
  output logic [DW-1:0] rf_wd
);

  localparam int            CW       = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] WAIT_MAX = CW'(MAX_WAIT);

  logic          hold_v_q;
  logic [AW-1:0] hold_addr_q;
  logic [DW-1:0] hold_data_q;
  logic [CW-1:0] wait_cnt_q, wait_cnt_d;
  logic          out_b_q;
  logic          force_b, grant_a, grant_b;

  assign force_b = hold_v_q && (wait_cnt_q == WAIT_MAX);
  assign grant_b = hold_v_q && (force_b || !a_valid);
  assign a_ready = !force_b;
  assign grant_a = a_valid && a_ready;
  assign b_ready = !hold_v_q || grant_b;

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (!hold_v_q || grant_b)      wait_cnt_d = '0;
    else if (wait_cnt_q != WAIT_MAX) wait_cnt_d = wait_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_v_q    <= 1'b0;
      hold_addr_q <= '0;
      hold_data_q <= '0;
      wait_cnt_q  <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      if (b_valid && b_ready) begin
        hold_v_q    <= 1'b1;
        hold_addr_q <= b_addr;
        hold_data_q <= b_data;
      end else if (grant_b) begin
        hold_v_q <= 1'b0;
      end
    end
  end

  // x0 writes still take the grant but never reach the register file.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we   <= 1'b0;
      rf_wa   <= '0;
      rf_wd   <= '0;
      out_b_q <= 1'b0;
    end else if (grant_b) begin
      rf_we   <= (hold_addr_q != '0);
      rf_wa   <= hold_addr_q;
      rf_wd   <= hold_data_q;
      out_b_q <= 1'b1;
    end else if (grant_a) begin
      rf_we   <= (a_addr != '0);
      rf_wa   <= a_addr;
      rf_wd   <= a_data;
      out_b_q <= 1'b0;
    end else begin
      rf_we <= 1'b0;
    end
  end

  rf_scoreboard u_sb (
    .clk         (clk),
    .rst_n       (rst_n),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .issue_ready (issue_ready),
    .q_ra1       (q_ra1),
    .q_ra2       (q_ra2),
    .q_busy1     (q_busy1),
    .q_busy2     (q_busy2),
    .clr_en      (rf_we && out_b_q),
    .clr_addr    (rf_wa)
  );

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter: arbitration, hold register, scoreboard and reset.
module tb_rf_wb_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        a_valid, a_ready, b_valid, b_ready;
  logic [4:0]  a_addr, b_addr, issue_rd, q_ra1, q_ra2, rf_wa;
  logic [31:0] a_data, b_data, rf_wd;
  logic        issue_valid, issue_ready, q_busy1, q_busy2, rf_we;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  rf_wb_arbiter #(.AW(5), .DW(32), .MAX_WAIT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(issue_ready),
    .q_ra1(q_ra1), .q_ra2(q_ra2), .q_busy1(q_busy1), .q_busy2(q_busy2),
    .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    a_valid = 0; a_addr = 0; a_data = 0;
    b_valid = 0; b_addr = 0; b_data = 0;
    issue_valid = 0; issue_rd = 0; q_ra1 = 0; q_ra2 = 0;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 0;
    issue_rd = 5'd7; q_ra1 = 5'd7;
    cyc(); cyc();
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL reset_we got %b want 0", rf_we); end
    checks++; if (rf_wa !== 5'd0) begin errors++; $display("FAIL reset_wa got %0d want 0", rf_wa); end
    checks++; if (rf_wd !== 32'd0) begin errors++; $display("FAIL reset_wd got %h want 0", rf_wd); end
    checks++; if (a_ready !== 1'b1 || b_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got a=%b b=%b want 1 1", a_ready, b_ready); end
    checks++; if (issue_ready !== 1'b1 || q_busy1 !== 1'b0) begin errors++; $display("FAIL reset_sb got ir=%b qb=%b want 1 0", issue_ready, q_busy1); end
    rst_n = 1;
    idle();
    cyc();
  endtask

  task automatic test_a_only();
    a_valid = 1; a_addr = 5'd5; a_data = 32'hDEADBEEF;
    #1;
    checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL a_only_ready got %b want 1", a_ready); end
    cyc();
    a_valid = 0;
    checks++; if (rf_we !== 1'b1 || rf_wa !== 5'd5 || rf_wd !== 32'hDEADBEEF) begin errors++; $display("FAIL a_only_write got we=%b wa=%0d wd=%h want 1 5 deadbeef", rf_we, rf_wa, rf_wd); end
    cyc();
    checks++; if (rf_we !== 1'b0 || rf_wa !== 5'd5) begin errors++; $display("FAIL a_only_idle got we=%b wa=%0d want 0 5", rf_we, rf_wa); end
  endtask

  task automatic test_b_scoreboard();
    issue_valid = 1; issue_rd = 5'd7;
    #1;
    checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL sb_issue_ready got %b want 1", issue_ready); end
    cyc();
    issue_valid = 0; q_ra1 = 5'd7;
    #1;
    checks++; if (q_busy1 !== 1'b1 || issue_ready !== 1'b0) begin errors++; $display("FAIL sb_busy got qb=%b ir=%b want 1 0", q_busy1, issue_ready); end
    b_valid = 1; b_addr = 5'd7; b_data = 32'h1234;
    #1;
    checks++; if (b_ready !== 1'b1) begin errors++; $display("FAIL sb_b_ready got %b want 1", b_ready); end
    cyc();
    b_valid = 0;
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL sb_hold_latency got we=%b want 0", rf_we); end
    cyc();
    checks++; if (rf_we !== 1'b1 || rf_wa !== 5'd7 || rf_wd !== 32'h1234) begin errors++; $display("FAIL sb_b_write got we=%b wa=%0d wd=%h want 1 7 1234", rf_we, rf_wa, rf_wd); end
    checks++; if (q_busy1 !== 1'b1) begin errors++; $display("FAIL sb_busy_during_write got %b want 1", q_busy1); end
    cyc();
    checks++; if (q_busy1 !== 1'b0 || rf_we !== 1'b0) begin errors++; $display("FAIL sb_cleared got qb=%b we=%b want 0 0", q_busy1, rf_we); end
    idle();
  endtask

  task automatic test_starvation();
    a_valid = 1; a_addr = 5'd1; a_data = 32'hA0;
    b_valid = 1; b_addr = 5'd2; b_data = 32'hB0B;
    #1;
    checks++; if (a_ready !== 1'b1 || b_ready !== 1'b1) begin errors++; $display("FAIL starve_start got a=%b b=%b want 1 1", a_ready, b_ready); end
    cyc();
    b_valid = 0;
    for (int k = 0; k < 4; k++) begin
      a_data = 32'hA1 + k;
      #1;
      checks++; if (a_ready !== 1'b1 || b_ready !== 1'b0) begin errors++; $display("FAIL starve_lose%0d got a=%b b=%b want 1 0", k, a_ready, b_ready); end
      cyc();
      checks++; if (rf_we !== 1'b1 || rf_wa !== 5'd1 || rf_wd !== 32'hA1 + k) begin errors++; $display("FAIL starve_a%0d got we=%b wa=%0d wd=%h want 1 1 %h", k, rf_we, rf_wa, rf_wd, 32'hA1 + k); end
    end
    checks++; if (a_ready !== 1'b0 || b_ready !== 1'b1) begin errors++; $display("FAIL starve_force got a=%b b=%b want 0 1", a_ready, b_ready); end
    cyc();
    checks++; if (rf_we !== 1'b1 || rf_wa !== 5'd2 || rf_wd !== 32'hB0B) begin errors++; $display("FAIL starve_b got we=%b wa=%0d wd=%h want 1 2 b0b", rf_we, rf_wa, rf_wd); end
    checks++; if (dut.wait_cnt_q !== 3'd0 || a_ready !== 1'b1) begin errors++; $display("FAIL starve_cnt got cnt=%0d a=%b want 0 1", dut.wait_cnt_q, a_ready); end
    idle();
    cyc();
  endtask

  task automatic test_x0();
    a_valid = 1; a_addr = 5'd0; a_data = 32'h55;
    cyc();
    a_valid = 0;
    checks++; if (rf_we !== 1'b0 || rf_wa !== 5'd0) begin errors++; $display("FAIL x0_a got we=%b wa=%0d want 0 0", rf_we, rf_wa); end
    issue_valid = 1; issue_rd = 5'd0;
    cyc();
    issue_valid = 0; q_ra1 = 5'd0; q_ra2 = 5'd7;
    #1;
    checks++; if (q_busy1 !== 1'b0 || issue_ready !== 1'b1 || q_busy2 !== 1'b0) begin errors++; $display("FAIL x0_issue got qb1=%b ir=%b qb2=%b want 0 1 0", q_busy1, issue_ready, q_busy2); end
    idle();
  endtask

  task automatic test_same_edge();
    b_valid = 1; b_addr = 5'd9; b_data = 32'h99;
    cyc();
    b_valid = 0;
    cyc();
    issue_valid = 1; issue_rd = 5'd9; q_ra2 = 5'd9;
    #1;
    checks++; if (rf_we !== 1'b1 || rf_wa !== 5'd9 || issue_ready !== 1'b1) begin errors++; $display("FAIL same_setup got we=%b wa=%0d ir=%b want 1 9 1", rf_we, rf_wa, issue_ready); end
    cyc();
    issue_valid = 0;
    checks++; if (q_busy2 !== 1'b1) begin errors++; $display("FAIL same_edge_set_wins got %b want 1", q_busy2); end
    b_valid = 1; b_addr = 5'd9; b_data = 32'h100;
    cyc();
    b_valid = 0;
    cyc(); cyc();
    checks++; if (q_busy2 !== 1'b0) begin errors++; $display("FAIL same_cleanup got %b want 0", q_busy2); end
    idle();
  endtask

  task automatic test_back_to_back();
    b_valid = 1; b_addr = 5'd10; b_data = 32'h10;
    cyc();
    b_addr = 5'd11; b_data = 32'h11;
    #1;
    checks++; if (b_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready got %b want 1", b_ready); end
    cyc();
    checks++; if (rf_we !== 1'b1 || rf_wa !== 5'd10 || rf_wd !== 32'h10) begin errors++; $display("FAIL b2b_w10 got we=%b wa=%0d wd=%h want 1 10 10", rf_we, rf_wa, rf_wd); end
    b_addr = 5'd12; b_data = 32'h12;
    cyc();
    b_valid = 0;
    checks++; if (rf_we !== 1'b1 || rf_wa !== 5'd11 || rf_wd !== 32'h11) begin errors++; $display("FAIL b2b_w11 got we=%b wa=%0d wd=%h want 1 11 11", rf_we, rf_wa, rf_wd); end
    cyc();
    checks++; if (rf_we !== 1'b1 || rf_wa !== 5'd12 || rf_wd !== 32'h12) begin errors++; $display("FAIL b2b_w12 got we=%b wa=%0d wd=%h want 1 12 12", rf_we, rf_wa, rf_wd); end
    cyc();
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL b2b_end got %b want 0", rf_we); end
    idle();
  endtask

  task automatic test_reset_mid();
    issue_valid = 1; issue_rd = 5'd3;
    cyc();
    issue_valid = 0; q_ra1 = 5'd3;
    b_valid = 1; b_addr = 5'd3; b_data = 32'h33;
    a_valid = 1; a_addr = 5'd4; a_data = 32'h44;
    cyc();
    b_valid = 0;
    checks++; if (rf_we !== 1'b1 || rf_wa !== 5'd4 || b_ready !== 1'b0 || q_busy1 !== 1'b1) begin errors++; $display("FAIL rmid_setup got we=%b wa=%0d br=%b qb=%b want 1 4 0 1", rf_we, rf_wa, b_ready, q_busy1); end
    rst_n = 0;
    a_valid = 0;
    #1;
    checks++; if (rf_we !== 1'b0 || b_ready !== 1'b1 || q_busy1 !== 1'b0) begin errors++; $display("FAIL rmid_async got we=%b br=%b qb=%b want 0 1 0", rf_we, b_ready, q_busy1); end
    cyc(); cyc();
    rst_n = 1;
    cyc();
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL rmid_after1 got %b want 0", rf_we); end
    cyc();
    checks++; if (rf_we !== 1'b0 || q_busy1 !== 1'b0) begin errors++; $display("FAIL rmid_after2 got we=%b qb=%b want 0 0", rf_we, q_busy1); end
    idle();
  endtask

  initial begin
    test_reset();
    test_a_only();
    test_b_scoreboard();
    test_starvation();
    test_x0();
    test_same_edge();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/rf_wb_arbiter.md
# rf_wb_arbiter

Write-back arbiter and scoreboard for the 32x32 two-read/one-write register file. It shares the file's single write port between the in-order ALU pipeline (source A) and the long-latency load/multi-cycle unit (source B). It also tracks destination registers that have an outstanding B write, so decode can stall on RAW hazards. It sits between the execute/memory stages and the register file's `we/wa/wd` inputs; its outputs are registered.

## Interface
Parameters:
- `AW`, 5: register address width (32 registers).
- `DW`, 32: data width.
- `MAX_WAIT`, 4: cycles a held B write may lose arbitration before it is forced through (range 1..15).

Ports:
- `clk`  in  1: single clock; all state updates on rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `a_valid`  in  1: ALU write-back request.
- `a_ready`  out  1: A accepted this cycle when `a_valid && a_ready`.
- `a_addr`  in  AW: A destination register.
- `a_data`  in  DW: A write data.
- `b_valid`  in  1: B write-back request.
- `b_ready`  out  1: B accepted into hold register when `b_valid && b_ready`.
- `b_addr`  in  AW: B destination register.
- `b_data`  in  DW: B write data.
- `issue_valid`  in  1: a B-type instruction is issuing; its `rd` is marked busy.
- `issue_rd`  in  AW: destination of the issuing instruction.
- `issue_ready`  out  1: `!busy[issue_rd]`; issue completes only when both `issue_valid` and `issue_ready` are high.
- `q_ra1`, `q_ra2`  in  AW: decode-stage source registers.
- `q_busy1`, `q_busy2`  out  1: combinational `busy[q_raN]`; always 0 for x0.
- `rf_we`  out  1: register-file write enable (registered).
- `rf_wa`  out  AW: register-file write address (registered).
- `rf_wd`  out  DW: register-file write data (registered).

## Operation
- **B hold register:** one entry (`hold_v`, `hold_addr`, `hold_data`).
  - `b_ready = !hold_v || grant_b`, so a new B request can be accepted in the same cycle the held one is granted.
- **Wait counter:** `wait_cnt` has `clog2(MAX_WAIT+1)` bits.
- **Arbitration, evaluated each cycle:**
  - `force_b = hold_v && wait_cnt == MAX_WAIT`.
  - `grant_b = hold_v && (force_b || !a_valid)`.
  - `a_ready = !force_b`.
  - `grant_a = a_valid && a_ready`.
  - At most one grant is issued per cycle.
- **Counter update:**
  - Increments when `hold_v && !grant_b`.
  - Clears on `grant_b` or when `!hold_v`.
  - Never exceeds `MAX_WAIT`.
- **Output stage:** on the next edge after a grant:
  - `rf_we <= 1`, `rf_wa`/`rf_wd` take the granted source's values, and a source tag `out_b` records which source was granted.
  - With no grant, `rf_we <= 0`; `rf_wa`/`rf_wd` hold their values.
  - A granted write to x0 produces `rf_we = 0` and still consumes the grant.
- **Scoreboard:** 32-bit `busy`; bit 0 is constant 0.
  - Set: issue completes with `issue_rd != 0`.
  - Clear: at the edge ending a cycle in which `rf_we && out_b`, bit `rf_wa` clears. This is the same edge the register file captures the data, so `q_busy` never deasserts before the data is readable.
  - Same-edge set and clear of the same bit: set wins.
  - A writes never touch the scoreboard; forwarding covers them.
- A B write whose `b_addr` is not busy is legal; it is written and clears nothing.

## Timing
- **Reset values:** `a_ready=1`, `b_ready=1`, `rf_we=0`, `rf_wa=0`, `rf_wd=0`, `hold_v=0`, `wait_cnt=0`, `busy=0`. `issue_ready` and `q_busy*` evaluate from the cleared `busy`.
- **Latency:** a request granted in cycle N drives `rf_*` in cycle N+1; the register file writes at the end of N+1.
  - An A request with no held B: granted in its acceptance cycle.
  - A B request: at least one extra cycle through the hold register (accepted in N, earliest grant N+1).
- **Starvation bound:** a held B write is granted within `MAX_WAIT+1` cycles of entering the hold register.
- **Back-to-back B:** with no A traffic, sustains one B write per cycle.
- **Reset mid-operation:** all held and pending writes are discarded, the scoreboard clears, and no `rf_we` pulse occurs during or immediately after reset.

## Structure
- Shared package `rf_pkg`: `AW`, `DW`, `NREG=32`, `REG_ZERO=5'd0`, and the type `reg_addr_t`. Decode and hazard logic also use it.
- One sub-module, `rf_scoreboard`: the busy vector, the set/clear priority, and the `issue_ready` and `q_busy1/2` lookups.
- Arbitration, the hold register and the output stage remain in `rf_wb_arbiter`.

## Test plan
- **A only:** `a_valid` with `a_addr=5`, `a_data=0xDEADBEEF` -> next cycle `rf_we=1`, `rf_wa=5`, `rf_wd=0xDEADBEEF`; `a_ready` stays 1.
- **B scoreboard:** issue `rd=7`, then `q_ra1=7` -> `q_busy1=1` and `issue_ready=0` for `rd=7`. Then a B write `7 <- 0x1234` with A idle -> `rf_we` the cycle after the grant; `q_busy1=0` the cycle after that.
- **Starvation:** `MAX_WAIT=4`, B held, A valid every cycle -> A granted 4 cycles, then `a_ready=0` for one cycle and B granted; `wait_cnt` returns to 0.
- **x0:** A write to x0 -> `rf_we=0`. `issue_rd=0` -> `busy` unchanged and `q_busy1=0` for `q_ra1=0`.
- **Same-edge set/clear:** B write clearing `rd=9` on the same edge as a new issue of `rd=9` -> `busy[9]=1` afterwards.
- **Reset mid-operation:** assert `rst_n=0` with B held and `busy[3]=1` -> immediately `rf_we=0`, `b_ready=1`, `busy=0`; no write issued after release.
